// File: rtl/ppc_types.sv
// Shared PowerPC execute-stage types.
// Divider decode bundle and CR0/XER exception flags.
package ppc_types;

  typedef struct packed {
    logic is_signed;
    logic is_word;
    logic set_cr0;
    logic set_ov;
  } div_decode_t;

  typedef struct packed {
    logic lt;
    logic gt;
    logic eq;
    logic so;
    logic ov;
    logic ov32;
  } cond_exception_t;

endpackage

// File: rtl/div_tag_fifo.sv
// In-order tag FIFO for div_arbiter.
// Holds the requester index of each operation in flight.
module div_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty,
  output logic             o_full
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd;
  logic [PTR_W-1:0] r_wr;
  logic [CNT_W-1:0] r_count;

  function automatic logic [PTR_W-1:0] f_inc(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // tag storage, written at the tail on push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else if (i_push) begin
      r_mem[r_wr] <= i_din;
    end
  end

  // pointers wrap independently; count tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= f_inc(r_wr);
      if (i_pop)  r_rd <= f_inc(r_rd);
      r_count <= r_count + CNT_W'(i_push)
               - CNT_W'(i_pop);
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));

endmodule

// File: rtl/div_arbiter.sv
// Shares one div_unit between several divide
// reservation stations; routes results back in order.
module div_arbiter
  import ppc_types::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int RS_ID_WIDTH  = 5,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*RS_ID_WIDTH-1:0] req_rs_id,
  input  logic [NUM_REQ*5-1:0]         req_result_reg_addr,
  input  logic [NUM_REQ*32-1:0]        req_op1,
  input  logic [NUM_REQ*32-1:0]        req_op2,
  input  div_decode_t [NUM_REQ-1:0]    req_control,
  output logic                         div_input_valid,
  input  logic                         div_input_ready,
  output logic [RS_ID_WIDTH-1:0]       div_rs_id,
  output logic [4:0]                   div_result_reg_addr,
  output logic [31:0]                  div_op1,
  output logic [31:0]                  div_op2,
  output div_decode_t                  div_control,
  input  logic                         div_output_valid,
  output logic                         div_output_ready,
  input  logic [RS_ID_WIDTH-1:0]       div_rs_id_out,
  input  logic [4:0]                   div_result_reg_addr_out,
  input  logic [31:0]                  div_result,
  input  cond_exception_t              div_cr0_xer,
  output logic [NUM_REQ-1:0]           resp_valid,
  input  logic [NUM_REQ-1:0]           resp_ready,
  output logic [RS_ID_WIDTH-1:0]       resp_rs_id,
  output logic [4:0]                   resp_result_reg_addr,
  output logic [31:0]                  resp_result,
  output cond_exception_t              resp_cr0_xer,
  output logic                         orphan_err
);

  localparam int REQ_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W     = $clog2(MAX_INFLIGHT + 1);

  logic [REQ_IDX_W-1:0] r_rr_ptr;
  logic                 r_lock;
  logic [REQ_IDX_W-1:0] r_lock_idx;
  logic                 r_orphan;

  logic [REQ_IDX_W-1:0] w_scan_idx;
  logic                 w_found;
  logic                 w_any;
  logic [REQ_IDX_W-1:0] w_grant;
  logic [REQ_IDX_W-1:0] w_sel;
  logic [REQ_IDX_W-1:0] w_rr_next;
  logic                 w_can_issue;
  logic                 w_div_valid;
  logic                 w_issue;
  logic                 w_pop;
  logic [REQ_IDX_W-1:0] w_head;
  logic [CNT_W-1:0]     w_count;
  logic                 w_empty;
  logic                 w_full;

  div_tag_fifo #(
    .WIDTH(REQ_IDX_W),
    .DEPTH(MAX_INFLIGHT)
  ) u_tags (
    .clk    (clk),
    .rst_n  (rst),
    .i_push (w_issue),
    .i_din  (w_grant),
    .i_pop  (w_pop),
    .o_head (w_head),
    .o_count(w_count),
    .o_empty(w_empty),
    .o_full (w_full)
  );

  // first valid requester at or after rr_ptr, wrapping
  always_comb begin
    w_found    = 1'b0;
    w_scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found &&
          req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
        w_found    = 1'b1;
        w_scan_idx = REQ_IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign w_any       = |req_valid;
  assign w_can_issue = !w_full &&
                       (w_count < CNT_W'(MAX_INFLIGHT));
  assign w_grant     = r_lock ? r_lock_idx : w_scan_idx;
  assign w_div_valid = rst && w_can_issue && (r_lock || w_any);
  assign w_issue     = w_div_valid && div_input_ready;
  assign w_sel       = w_div_valid ? w_grant : '0;
  assign w_rr_next   = (w_grant == REQ_IDX_W'(NUM_REQ - 1)) ?
                       '0 : w_grant + 1'b1;

  assign div_input_valid     = w_div_valid;
  assign div_rs_id           =
    req_rs_id[w_sel*RS_ID_WIDTH +: RS_ID_WIDTH];
  assign div_result_reg_addr = req_result_reg_addr[w_sel*5 +: 5];
  assign div_op1             = req_op1[w_sel*32 +: 32];
  assign div_op2             = req_op2[w_sel*32 +: 32];
  assign div_control         = req_control[w_sel];

  // zero-latency accept for the granted requester only
  always_comb begin
    req_ready = '0;
    if (w_issue) req_ready[w_grant] = 1'b1;
  end

  // results go to the oldest tag; empty FIFO drains the divider
  always_comb begin
    resp_valid = '0;
    if (rst && div_output_valid && !w_empty)
      resp_valid[w_head] = 1'b1;
  end

  assign div_output_ready = rst && (w_empty || resp_ready[w_head]);
  assign w_pop = rst && div_output_valid && !w_empty &&
                 resp_ready[w_head];

  assign resp_rs_id           = div_rs_id_out;
  assign resp_result_reg_addr = div_result_reg_addr_out;
  assign resp_result          = div_result;
  assign resp_cr0_xer         = div_cr0_xer;
  assign orphan_err           = r_orphan;

  // round-robin pointer and stall lock on the granted slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr   <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else if (w_issue) begin
      r_rr_ptr <= w_rr_next;
      r_lock   <= 1'b0;
    end else if (w_div_valid) begin
      r_lock     <= 1'b1;
      r_lock_idx <= w_grant;
    end
  end

  // sticky flag: a result came back with no tag to route it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_orphan <= 1'b0;
    end else if (div_output_valid && w_empty) begin
      r_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Randomized bench for div_arbiter with a queue-based
// reference model and a small divider model.
module tb_div_arbiter;
  import ppc_types::*;

  localparam int N   = 4;
  localparam int RSW = 5;
  localparam int MI  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  logic [N*RSW-1:0]     req_rs_id;
  logic [N*5-1:0]       req_result_reg_addr;
  logic [N*32-1:0]      req_op1;
  logic [N*32-1:0]      req_op2;
  div_decode_t [N-1:0]  req_control;
  logic                 div_input_valid;
  logic                 div_input_ready;
  logic [RSW-1:0]       div_rs_id;
  logic [4:0]           div_result_reg_addr;
  logic [31:0]          div_op1;
  logic [31:0]          div_op2;
  div_decode_t          div_control;
  logic                 div_output_valid;
  logic                 div_output_ready;
  logic [RSW-1:0]       div_rs_id_out;
  logic [4:0]           div_result_reg_addr_out;
  logic [31:0]          div_result;
  cond_exception_t      div_cr0_xer;
  logic [N-1:0]         resp_valid;
  logic [N-1:0]         resp_ready;
  logic [RSW-1:0]       resp_rs_id;
  logic [4:0]           resp_result_reg_addr;
  logic [31:0]          resp_result;
  cond_exception_t      resp_cr0_xer;
  logic                 orphan_err;

  div_arbiter #(
    .NUM_REQ(N), .RS_ID_WIDTH(RSW), .MAX_INFLIGHT(MI)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs_id(req_rs_id),
    .req_result_reg_addr(req_result_reg_addr),
    .req_op1(req_op1), .req_op2(req_op2),
    .req_control(req_control),
    .div_input_valid(div_input_valid),
    .div_input_ready(div_input_ready),
    .div_rs_id(div_rs_id),
    .div_result_reg_addr(div_result_reg_addr),
    .div_op1(div_op1), .div_op2(div_op2),
    .div_control(div_control),
    .div_output_valid(div_output_valid),
    .div_output_ready(div_output_ready),
    .div_rs_id_out(div_rs_id_out),
    .div_result_reg_addr_out(div_result_reg_addr_out),
    .div_result(div_result), .div_cr0_xer(div_cr0_xer),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rs_id(resp_rs_id),
    .resp_result_reg_addr(resp_result_reg_addr),
    .resp_result(resp_result), .resp_cr0_xer(resp_cr0_xer),
    .orphan_err(orphan_err)
  );

  typedef struct {
    logic [RSW-1:0]  rs;
    logic [4:0]      ra;
    logic [31:0]     res;
    cond_exception_t cr;
    int              due;
  } dop_t;

  int   n_pass = 0;
  int   n_tot  = 0;
  int   cyc    = 0;
  int   m_rr;
  bit   m_lock;
  int   m_lidx;
  bit   m_orph;
  int   m_tags[$];
  dop_t dq[$];
  int   dut_log[$];
  int   lat_min = 2;
  int   lat_max = 2;
  int   s_g;
  bit   s_issue, s_lockset, s_ret, s_orph;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h cycle %0d",
                  nm, act, exp, cyc);
  endtask

  function automatic logic [31:0] ref_div(logic [31:0] a,
                                          logic [31:0] b);
    return (b == 0) ? 32'hFFFF_FFFF : a / b;
  endfunction

  function automatic int model_grant();
    if (m_lock) return m_lidx;
    for (int k = 0; k < N; k++)
      if (req_valid[(m_rr + k) % N]) return (m_rr + k) % N;
    return 0;
  endfunction

  task automatic set_op(input int i, input int rs,
                        input int a, input int b);
    req_rs_id[i*RSW +: RSW]         = RSW'(rs);
    req_result_reg_addr[i*5 +: 5]   = 5'(i + 1);
    req_op1[i*32 +: 32]             = 32'(a);
    req_op2[i*32 +: 32]             = 32'(b);
    req_control[i]                  = div_decode_t'(4'(i + rs));
  endtask

  task automatic drive_div();
    if (dq.size() > 0 && dq[0].due <= cyc) begin
      div_output_valid        = 1'b1;
      div_rs_id_out           = dq[0].rs;
      div_result_reg_addr_out = dq[0].ra;
      div_result              = dq[0].res;
      div_cr0_xer             = dq[0].cr;
    end else begin
      div_output_valid        = 1'b0;
      div_rs_id_out           = '0;
      div_result_reg_addr_out = '0;
      div_result              = '0;
      div_cr0_xer             = '0;
    end
  endtask

  task automatic sample();
    int g;
    bit edv;
    logic [N-1:0] erdy, ersp;
    bit eor;
    drive_div();
    #1;
    g    = model_grant();
    edv  = rst && (m_tags.size() < MI) && (m_lock || |req_valid);
    erdy = (edv && div_input_ready) ? (N'(1) << g) : '0;
    chk("div_input_valid", 64'(div_input_valid), 64'(edv));
    chk("req_ready", 64'(req_ready), 64'(erdy));
    if (edv)
      chk("div_fields",
          {div_rs_id, div_result_reg_addr, div_op1,
           4'(div_control)},
          {req_rs_id[g*RSW +: RSW], req_result_reg_addr[g*5 +: 5],
           req_op1[g*32 +: 32], 4'(req_control[g])});
    if (edv)
      chk("div_op2", 64'(div_op2), 64'(req_op2[g*32 +: 32]));
    if (m_tags.size() > 0) begin
      ersp = (rst && div_output_valid) ? (N'(1) << m_tags[0]) : '0;
      eor  = rst && resp_ready[m_tags[0]];
    end else begin
      ersp = '0;
      eor  = rst;
    end
    chk("resp_valid", 64'(resp_valid), 64'(ersp));
    chk("div_output_ready", 64'(div_output_ready), 64'(eor));
    if (div_output_valid)
      chk("resp_fields",
          {resp_rs_id, resp_result_reg_addr, resp_result,
           6'(resp_cr0_xer)},
          {dq[0].rs, dq[0].ra, dq[0].res, 6'(dq[0].cr)});
    chk("orphan_err", 64'(orphan_err), 64'(rst ? m_orph : 1'b0));
    if (rst && |resp_valid && div_output_ready)
      dut_log.push_back($clog2(resp_valid));
    s_g       = g;
    s_issue   = edv && div_input_ready;
    s_lockset = edv && !div_input_ready;
    s_ret     = rst && div_output_valid && m_tags.size() > 0 &&
                resp_ready[m_tags[0]];
    s_orph    = rst && div_output_valid && m_tags.size() == 0;
  endtask

  task automatic advance();
    dop_t d;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst) begin
      m_rr = 0; m_lock = 0; m_orph = 0;
      m_tags.delete();
      dq.delete();
    end else begin
      if (s_ret) begin
        void'(m_tags.pop_front());
        void'(dq.pop_front());
      end
      if (s_orph) begin
        m_orph = 1;
        void'(dq.pop_front());
      end
      if (s_issue) begin
        m_tags.push_back(s_g);
        m_rr   = (s_g + 1) % N;
        m_lock = 0;
        d.rs  = req_rs_id[s_g*RSW +: RSW];
        d.ra  = req_result_reg_addr[s_g*5 +: 5];
        d.res = ref_div(req_op1[s_g*32 +: 32], req_op2[s_g*32 +: 32]);
        d.cr  = cond_exception_t'(6'(req_op1[s_g*32 +: 32] ^
                                    req_op2[s_g*32 +: 32]));
        d.due = cyc + $urandom_range(lat_max, lat_min);
        if (dq.size() > 0 && dq[dq.size()-1].due > d.due)
          d.due = dq[dq.size()-1].due;
        dq.push_back(d);
        req_valid[s_g] = 1'b0;
      end else if (s_lockset) begin
        m_lock = 1;
        m_lidx = s_g;
      end
    end
    @(negedge clk);
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_valid = '0;
    div_input_ready = 1'b0;
    resp_ready = '0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic drive_rand();
    for (int i = 0; i < N; i++) begin
      if (!req_valid[i] && $urandom_range(99) < 40) begin
        req_valid[i] = 1'b1;
        set_op(i, int'($urandom_range(31)), int'($urandom),
               ($urandom_range(9) == 0) ? 0 :
               int'($urandom_range(5000, 1)));
      end
      resp_ready[i] = ($urandom_range(99) < 60);
    end
    div_input_ready = ($urandom_range(99) < 70);
  endtask

  int  order[5] = '{0, 1, 2, 3, 0};
  bit  found;

  initial begin
    rst = 1'b0;
    req_valid = '0; req_rs_id = '0; req_result_reg_addr = '0;
    req_op1 = '0; req_op2 = '0; req_control = '0;
    div_input_ready = 1'b0; resp_ready = '0;
    m_rr = 0; m_lock = 0; m_lidx = 0; m_orph = 0;
    @(negedge clk);
    req_valid = 4'b1111;
    sample();
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    chk("reset_div_valid", 64'(div_input_valid), 64'd0);
    chk("reset_orphan", 64'(orphan_err), 64'd0);
    advance();
    do_reset();

    // single requester
    set_op(2, 9, 100, 7);
    req_valid = 4'b0100;
    div_input_ready = 1'b1;
    resp_ready = 4'b1111;
    sample();
    chk("t1_req_ready", 64'(req_ready), 64'b0100);
    advance();
    found = 0;
    for (int t = 0; t < 10 && !found; t++) begin
      sample();
      if (resp_valid != 0) begin
        found = 1;
        chk("t1_resp_valid", 64'(resp_valid), 64'b0100);
        chk("t1_resp_result", 64'(resp_result), 64'd14);
      end
      advance();
    end
    if (!found) chk("t1_resp_timeout", 64'd0, 64'd1);
    for (int i = 0; i < N; i++) set_op(i, i, 50 + i, 3);
    req_valid = 4'b1111;
    sample();
    chk("t1_rr_next", 64'(req_ready), 64'b1000);
    advance();
    do_reset();

    // round-robin order and in-order return
    dut_log.delete();
    div_input_ready = 1'b1;
    resp_ready = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i]) set_op(i, 4 * k + i, 1000 + k, i + 1);
      req_valid = 4'b1111;
      sample();
      chk("t2_grant", 64'(req_ready), 64'(N'(1) << order[k]));
      advance();
    end
    req_valid = '0;
    for (int t = 0; t < 12; t++) step();
    chk("t2_resp_count", 64'(dut_log.size()), 64'd5);
    for (int k = 0; k < 5 && k < dut_log.size(); k++)
      chk("t2_resp_order", 64'(dut_log[k]), 64'(order[k]));
    do_reset();

    // backpressure lock
    resp_ready = 4'b1111;
    set_op(0, 16, 40, 2);
    set_op(1, 17, 41, 2);
    set_op(2, 18, 42, 2);
    req_valid = 4'b0010;
    div_input_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      sample();
      chk("t3_hold_rs", 64'(div_rs_id), 64'd17);
      chk("t3_no_ready", 64'(req_ready), 64'd0);
      advance();
      req_valid[0] = 1'b1;
    end
    div_input_ready = 1'b1;
    sample();
    chk("t3_issue1", 64'(req_ready), 64'b0010);
    advance();
    req_valid[2] = 1'b1;
    sample();
    chk("t3_issue2", 64'(req_ready), 64'b0100);
    advance();
    sample();
    chk("t3_issue0", 64'(req_ready), 64'b0001);
    advance();
    do_reset();

    // credit limit
    div_input_ready = 1'b1;
    resp_ready = '0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i]) set_op(i, 8 + 4 * k + i, 77, 7);
      req_valid = 4'b1111;
      sample();
      chk("t4_fill", 64'(req_ready), 64'(N'(1) << k));
      advance();
    end
    req_valid = 4'b1111;
    sample();
    chk("t4_full_ready", 64'(req_ready), 64'd0);
    chk("t4_full_valid", 64'(div_input_valid), 64'd0);
    advance();
    resp_ready = 4'b1111;
    sample();
    chk("t4_ret_valid", 64'(resp_valid), 64'b0001);
    chk("t4_ret_noissue", 64'(req_ready), 64'd0);
    advance();
    resp_ready = '0;
    sample();
    chk("t4_one_more", 64'(req_ready), 64'b0001);
    advance();
    req_valid[0] = 1'b1;
    sample();
    chk("t4_full_again", 64'(div_input_valid), 64'd0);
    advance();
    do_reset();

    // result backpressure on requester 3
    resp_ready = 4'b0111;
    div_input_ready = 1'b1;
    set_op(3, 21, 1000, 8);
    req_valid = 4'b1000;
    step();
    found = 0;
    for (int t = 0; t < 10 && !found; t++) begin
      sample();
      if (div_output_valid) found = 1;
      else advance();
    end
    if (!found) chk("t5_valid_timeout", 64'd0, 64'd1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) sample();
      chk("t5_resp_valid", 64'(resp_valid), 64'b1000);
      chk("t5_out_ready", 64'(div_output_ready), 64'd0);
      chk("t5_result", 64'(resp_result), 64'd125);
      advance();
    end
    resp_ready = 4'b1111;
    sample();
    chk("t5_release", 64'(div_output_ready), 64'd1);
    advance();
    do_reset();

    // reset mid-flight then orphan result
    div_input_ready = 1'b1;
    resp_ready = '0;
    set_op(0, 3, 90, 9);
    set_op(1, 4, 80, 8);
    req_valid = 4'b0011;
    step();
    step();
    for (int t = 0; t < 4; t++) step();
    rst = 1'b0;
    req_valid = 4'b1111;
    sample();
    chk("t6_rst_ready", 64'(req_ready), 64'd0);
    chk("t6_rst_dvalid", 64'(div_input_valid), 64'd0);
    chk("t6_rst_resp", 64'(resp_valid), 64'd0);
    chk("t6_rst_oready", 64'(div_output_ready), 64'd0);
    advance();
    step();
    rst = 1'b1;
    req_valid = '0;
    dq.push_back('{rs: 5'd7, ra: 5'd2, res: 32'hDEAD,
                   cr: cond_exception_t'(6'd0), due: cyc});
    sample();
    chk("t6_drain", 64'(div_output_ready), 64'd1);
    chk("t6_no_resp", 64'(resp_valid), 64'd0);
    advance();
    sample();
    chk("t6_orphan", 64'(orphan_err), 64'd1);
    advance();
    lat_min = 0;
    lat_max = 4;
    for (int t = 0; t < 20; t++) begin
      drive_rand();
      step();
    end
    chk("t6_sticky", 64'(orphan_err), 64'd1);
    do_reset();

    // randomized traffic
    for (int t = 0; t < 3000; t++) begin
      if (t == 1500) do_reset();
      drive_rand();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
